// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execute controller wrapped around an external
// 4-bit ALU. It accepts one 12-bit instruction per valid/ready handshake,
// reads operands from a 4x4 register file and drives the ALU during EXEC.
// It captures the ALU result and flags, then retires in WB.
// Sequence: IDLE -> DECODE -> EXEC -> WB -> IDLE. done pulses in the IDLE
// cycle that follows WB.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   instr_valid/instr_ready instruction handshake; instr = {op,rd,rs,imm}
//   alu_op_sel/opcode/opA/opB  drive to the ALU (zero outside ALU EXEC)
//   alu_res, alu_z/c/o/n    result and flags returned by the ALU
//   flags                   status register {Z,C,O,N}
//   done                    one-cycle retire pulse
//   err                     sticky illegal-opcode flag, cleared by reset only
//   dbg_addr/dbg_data       combinational register-file read port
//
// Optional macro ALU_EXEC_ZERO_REG_EN: R0 reads as zero and ignores writes.
module alu_exec_ctrl #(
  parameter int DATA_W = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [11:0]       instr,
  output logic [1:0]        alu_op_sel,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_opA,
  output logic [DATA_W-1:0] alu_opB,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_o,
  input  logic              alu_n,
  output logic [3:0]        flags,
  output logic              done,
  output logic              err,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t state, state_nx;

  logic [11:0]                      ir;
  logic [DATA_W-1:0]                opa_q, opb_q, res_q;
  logic [3:0]                       aflg_q;
  logic [NREG-1:0][DATA_W-1:0]      rf;
  logic [NREG-1:0][DATA_W-1:0]      rf_view;

  logic [3:0]        op;
  logic [AW-1:0]     rd, rs;
  logic [DATA_W-1:0] imm;
  assign op  = ir[11:8];
  assign rd  = ir[7:6];
  assign rs  = ir[5:4];
  assign imm = ir[3:0];

  // Decode. CMP is an ALU op that updates flags but skips the register write.
  logic is_alu, is_ill, is_ldi, is_mov, wr_en, wr_ok;
  logic [DATA_W-1:0] wdata;
  assign is_alu = ((op >= 4'h1) && (op <= 4'h9)) || (op == 4'hC);
  assign is_ill = (op >= 4'hD);
  assign is_ldi = (op == 4'hA);
  assign is_mov = (op == 4'hB);
  assign wr_en  = ((op >= 4'h1) && (op <= 4'h9)) || is_ldi || is_mov;
  // MOV uses the R[rs] value latched in DECODE.
  assign wdata  = is_ldi ? imm : (is_mov ? opb_q : res_q);

  // Architectural view of the register file; every read goes through it.
  always_comb begin
    rf_view = rf;
`ifdef ALU_EXEC_ZERO_REG_EN
    rf_view[0] = '0;
`endif
  end

`ifdef ALU_EXEC_ZERO_REG_EN
  assign wr_ok = wr_en && (rd != '0);
`else
  assign wr_ok = wr_en;
`endif

  assign dbg_data    = rf_view[dbg_addr];
  assign instr_ready = (state == IDLE);

  always_comb begin
    state_nx   = state;
    alu_op_sel = 2'b00;
    alu_opcode = 4'h0;
    alu_opA    = '0;
    alu_opB    = '0;
    case (state)
      IDLE:   if (instr_valid) state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC: begin
        state_nx = WB;
        if (is_alu) begin
          alu_opA = opa_q;
          alu_opB = opb_q;
          if (op <= 4'h7) begin
            alu_op_sel = 2'b01;
            alu_opcode = op;
          end else if (op == 4'h8) begin
            alu_op_sel = 2'b10;
          end else begin
            alu_op_sel = 2'b11;  // SUB and CMP
          end
        end
      end
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ir     <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      aflg_q <= '0;
      rf     <= '0;
      flags  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE:   if (instr_valid) ir <= instr;
        DECODE: begin
          opa_q <= rf_view[rd];
          opb_q <= rf_view[rs];
        end
        EXEC: begin
          res_q  <= alu_res;
          aflg_q <= {alu_z, alu_c, alu_o, alu_n};
        end
        WB: begin
          done <= 1'b1;
          if (is_ill) err <= 1'b1;
          if (wr_ok)  rf[rd] <= wdata;
          if (is_alu) flags <= aflg_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [11:0] instr = '0;
  logic [1:0]  alu_op_sel;
  logic [3:0]  alu_opcode, alu_opA, alu_opB, alu_res;
  logic        alu_z, alu_c, alu_o, alu_n;
  logic [3:0]  flags;
  logic        done, err;
  logic [1:0]  dbg_addr = '0;
  logic [3:0]  dbg_data;

  int checks = 0;
  int failures = 0;

  // Captured during the EXEC cycle of the last issued instruction.
  logic [1:0] ex_sel;
  logic [3:0] ex_opc, ex_a, ex_b;
  int         lat;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_op_sel(alu_op_sel), .alu_opcode(alu_opcode),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_res(alu_res),
    .alu_z(alu_z), .alu_c(alu_c), .alu_o(alu_o), .alu_n(alu_n),
    .flags(flags), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: 1 AND, 2 OR, 3 XOR, other logic ops NOT A; ADD; SUB (C = no borrow).
  logic [4:0] t5;
  always_comb begin
    t5 = '0; alu_res = '0; alu_c = 1'b0; alu_o = 1'b0;
    case (alu_op_sel)
      2'b01: case (alu_opcode)
        4'h1: alu_res = alu_opA & alu_opB;
        4'h2: alu_res = alu_opA | alu_opB;
        4'h3: alu_res = alu_opA ^ alu_opB;
        default: alu_res = ~alu_opA;
      endcase
      2'b10: begin
        t5 = {1'b0, alu_opA} + {1'b0, alu_opB};
        alu_res = t5[3:0]; alu_c = t5[4];
        alu_o = (alu_opA[3] == alu_opB[3]) && (alu_res[3] != alu_opA[3]);
      end
      2'b11: begin
        t5 = {1'b0, alu_opA} + {1'b0, ~alu_opB} + 5'd1;
        alu_res = t5[3:0]; alu_c = t5[4];
        alu_o = (alu_opA[3] != alu_opB[3]) && (alu_res[3] != alu_opA[3]);
      end
      default: ;
    endcase
    alu_z = (alu_res == 4'h0);
    alu_n = alu_res[3];
  end

  // Offer one instruction, drop valid once accepted, and wait (bounded) for done.
  // lat = number of cycles after the handshake cycle until done (expected 4).
  task automatic issue(input logic [11:0] ins, input logic [1:0] dbg);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1; dbg_addr = dbg;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (k == 2) begin
        ex_sel = alu_op_sel; ex_opc = alu_opcode; ex_a = alu_opA; ex_b = alu_opB;
      end
      if (done) begin lat = k; break; end
    end
    checks++;
    if (lat == 0) begin
      failures++;
      $display("FAIL done_timeout instr=%h got no done within 8 cycles", ins);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({instr_ready, done, err, flags} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl got rdy/done/err/flags=%b want 1000000",
               {instr_ready, done, err, flags});
    end
    checks++;
    if ({alu_op_sel, alu_opcode, alu_opA, alu_opB} !== 14'h0) begin
      failures++;
      $display("FAIL reset_alu got %h want 0", {alu_op_sel, alu_opcode, alu_opA, alu_opB});
    end
    for (int r = 0; r < 4; r++) begin
      dbg_addr = r[1:0]; #1;
      checks++;
      if (dbg_data !== 4'h0) begin
        failures++;
        $display("FAIL reset_reg R%0d got %h want 0", r, dbg_data);
      end
    end
  endtask

  // LDI R1,5 with per-cycle checks of ready and done.
  task automatic test_ldi_latency;
    logic [3:0] rdy_seen, done_seen;
    @(negedge clk);
    instr = 12'hA45; instr_valid = 1'b1; dbg_addr = 2'd1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      rdy_seen[k-1] = instr_ready; done_seen[k-1] = done;
    end
    checks++;
    if (rdy_seen !== 4'b1000) begin
      failures++;
      $display("FAIL ldi_ready got N+4..N+1=%b want 1000", rdy_seen);
    end
    checks++;
    if (done_seen !== 4'b1000) begin
      failures++;
      $display("FAIL ldi_done got N+4..N+1=%b want 1000", done_seen);
    end
    checks++;
    if (dbg_data !== 4'h5 || flags !== 4'b0000) begin
      failures++;
      $display("FAIL ldi_result got R1=%h flags=%b want 5 0000", dbg_data, flags);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL ldi_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_add;
    issue(12'hA83, 2'd2);  // LDI R2,3
    checks++;
    if (dbg_data !== 4'h3) begin
      failures++;
      $display("FAIL ldi_r2 got %h want 3", dbg_data);
    end
    issue(12'h860, 2'd1);  // ADD R1,R2
    checks++;
    if (ex_sel !== 2'b10 || ex_a !== 4'h5 || ex_b !== 4'h3) begin
      failures++;
      $display("FAIL add_exec got sel=%b a=%h b=%h want 10 5 3", ex_sel, ex_a, ex_b);
    end
    checks++;
    if (lat != 4 || dbg_data !== 4'h8 || flags !== 4'b0011) begin
      failures++;
      $display("FAIL add_result got lat=%0d R1=%h flags=%b want 4 8 0011", lat, dbg_data, flags);
    end
  endtask

  task automatic test_sub;
    issue(12'h9A0, 2'd2);  // SUB R2,R2
    checks++;
    if (ex_sel !== 2'b11 || ex_a !== 4'h3 || ex_b !== 4'h3) begin
      failures++;
      $display("FAIL sub_exec got sel=%b a=%h b=%h want 11 3 3", ex_sel, ex_a, ex_b);
    end
    checks++;
    if (dbg_data !== 4'h0 || flags !== 4'b1100) begin
      failures++;
      $display("FAIL sub_result got R2=%h flags=%b want 0 1100", dbg_data, flags);
    end
  endtask

  task automatic test_cmp;
    issue(12'hC90, 2'd2);  // CMP R2,R1
    checks++;
    if (dbg_data !== 4'h0 || flags !== 4'b0011) begin
      failures++;
      $display("FAIL cmp_result got R2=%h flags=%b want 0 0011", dbg_data, flags);
    end
    dbg_addr = 2'd1; #1;
    checks++;
    if (dbg_data !== 4'h8) begin
      failures++;
      $display("FAIL cmp_r1 got %h want 8", dbg_data);
    end
  endtask

  task automatic test_logic;
    issue(12'hAC6, 2'd3);  // LDI R3,6; flags must survive
    checks++;
    if (dbg_data !== 4'h6 || flags !== 4'b0011) begin
      failures++;
      $display("FAIL ldi_r3 got R3=%h flags=%b want 6 0011", dbg_data, flags);
    end
    issue(12'h370, 2'd1);  // XOR R1,R3
    checks++;
    if (ex_sel !== 2'b01 || ex_opc !== 4'h3 || ex_a !== 4'h8 || ex_b !== 4'h6) begin
      failures++;
      $display("FAIL xor_exec got sel=%b opc=%h a=%h b=%h want 01 3 8 6",
               ex_sel, ex_opc, ex_a, ex_b);
    end
    checks++;
    if (dbg_data !== 4'hE || flags !== 4'b0001) begin
      failures++;
      $display("FAIL xor_result got R1=%h flags=%b want e 0001", dbg_data, flags);
    end
  endtask

  // Illegal op with instr_valid held through the busy cycles.
  task automatic test_illegal;
    int dones;
    dones = 0;
    @(negedge clk);
    instr = 12'hF00; instr_valid = 1'b1; dbg_addr = 2'd1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) instr_valid = 1'b0;  // drop in the done cycle, before its edge
      if (done) dones++;
    end
    checks++;
    if (dones != 1 || err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_done got dones=%0d err=%b want 1 1", dones, err);
    end
    checks++;
    if (dbg_data !== 4'hE || flags !== 4'b0001 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL illegal_state got R1=%h flags=%b rdy=%b want e 0001 1",
               dbg_data, flags, instr_ready);
    end
    issue(12'hAC7, 2'd3);  // LDI R3,7
    checks++;
    if (dbg_data !== 4'h7 || err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_sticky got R3=%h err=%b want 7 1", dbg_data, err);
    end
  endtask

  task automatic test_reset_mid;
    logic dseen;
    @(negedge clk);
    instr = 12'h860; instr_valid = 1'b1; dbg_addr = 2'd1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);  // EXEC
    checks++;
    if (alu_op_sel !== 2'b10) begin
      failures++;
      $display("FAIL midrst_exec got sel=%b want 10", alu_op_sel);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({alu_op_sel, alu_opcode, alu_opA, alu_opB, flags, done, err, dbg_data} !== 24'h0) begin
      failures++;
      $display("FAIL midrst_outputs got %h want 0",
               {alu_op_sel, alu_opcode, alu_opA, alu_opB, flags, done, err, dbg_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || dbg_data !== 4'h0) begin
      failures++;
      $display("FAIL midrst_release got rdy=%b R1=%h want 1 0", instr_ready, dbg_data);
    end
    dseen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    checks++;
    if (dseen !== 1'b0 || dbg_data !== 4'h0 || flags !== 4'h0) begin
      failures++;
      $display("FAIL midrst_noeffect got done=%b R1=%h flags=%b want 0 0 0000",
               dseen, dbg_data, flags);
    end
  endtask

  initial begin
    test_reset;
    test_ldi_latency;
    test_add;
    test_sub;
    test_cmp;
    test_logic;
    test_illegal;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1);
  end
endmodule
